// File: rtl/ace_rd_arbiter.sv
// Two-requester ACE read arbiter: round-robin AR grant, one transaction in flight,
// R channel steered back to the granted requester, RACK issued after the last beat.
module ace_rd_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    // requester side (index 0 = IFU, index 1 = LSU)
    input  logic [1:0]                s_arvalid,
    output logic [1:0]                s_arready,
    input  logic [2*ADDR_WIDTH-1:0]   s_araddr,
    input  logic [15:0]               s_arlen,
    input  logic [7:0]                s_arsnoop,
    output logic [1:0]                s_rvalid,
    input  logic [1:0]                s_rready,
    output logic [DATA_WIDTH-1:0]     s_rdata,
    output logic [3:0]                s_rresp,
    output logic                      s_rlast,
    // downstream side
    output logic                      m_arvalid,
    input  logic                      m_arready,
    output logic [ID_WIDTH-1:0]       m_arid,
    output logic [ADDR_WIDTH-1:0]     m_araddr,
    output logic [7:0]                m_arlen,
    output logic [3:0]                m_arsnoop,
    input  logic                      m_rvalid,
    output logic                      m_rready,
    input  logic [ID_WIDTH-1:0]       m_rid,
    input  logic [DATA_WIDTH-1:0]     m_rdata,
    input  logic [3:0]                m_rresp,
    input  logic                      m_rlast,
    output logic                      m_rack,
    output logic                      err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_ACK  = 2'd3;

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    // Holds the current grant and doubles as the last-grant record for round-robin.
    logic                  grant;
    logic                  grant_nxt;
    logic [7:0]            beat_cnt;
    logic [7:0]            exp_len;
    logic [ID_WIDTH-1:0]   grant_id;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [7:0]            sel_len;
    logic [3:0]            sel_snoop;
    logic                  ar_hs;
    logic                  r_hs;
    logic                  beat_err;

    // NOTE: every signal assigned in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant_nxt = grant;
        case (s_arvalid)
            2'b01:   grant_nxt = 1'b0;
            2'b10:   grant_nxt = 1'b1;
            2'b11:   grant_nxt = ~grant;
            default: grant_nxt = grant;
        endcase
    end

    always_comb begin
        grant_id    = '0;
        grant_id[0] = grant;
    end

    assign sel_addr  = grant ? s_araddr[2*ADDR_WIDTH-1:ADDR_WIDTH] : s_araddr[ADDR_WIDTH-1:0];
    assign sel_len   = grant ? s_arlen[15:8]   : s_arlen[7:0];
    assign sel_snoop = grant ? s_arsnoop[7:4]  : s_arsnoop[3:0];

    assign ar_hs = (state == ST_ADDR) && m_arready;
    assign r_hs  = (state == ST_DATA) && m_rvalid && s_rready[grant];

    // A beat is malformed if its ID is foreign or RLAST disagrees with the requested length.
    assign beat_err = (m_rid != grant_id)
                    || ( m_rlast && (beat_cnt != exp_len))
                    || (!m_rlast && (beat_cnt == exp_len));

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (|s_arvalid) state_nxt = ST_ADDR;
            ST_ADDR: if (ar_hs)      state_nxt = ST_DATA;
            ST_DATA: if (r_hs && m_rlast) state_nxt = ST_ACK;
            ST_ACK:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        m_arvalid = 1'b0;
        m_arid    = '0;
        m_araddr  = '0;
        m_arlen   = '0;
        m_arsnoop = '0;
        s_arready = '0;
        s_rvalid  = '0;
        m_rready  = 1'b0;
        s_rdata   = '0;
        s_rresp   = '0;
        s_rlast   = 1'b0;
        m_rack    = 1'b0;
        case (state)
            ST_ADDR: begin
                m_arvalid        = 1'b1;
                m_arid           = grant_id;
                m_araddr         = sel_addr;
                m_arlen          = sel_len;
                m_arsnoop        = sel_snoop;
                s_arready[grant] = m_arready;
            end
            ST_DATA: begin
                s_rvalid[grant] = m_rvalid;
                m_rready        = s_rready[grant];
                s_rdata         = m_rdata;
                s_rresp         = m_rresp;
                s_rlast         = m_rlast;
            end
            ST_ACK:  m_rack = 1'b1;
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            grant    <= 1'b1;
            beat_cnt <= '0;
            exp_len  <= '0;
            err      <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state == ST_IDLE) && (|s_arvalid))
                grant <= grant_nxt;
            if (ar_hs) begin
                beat_cnt <= '0;
                exp_len  <= sel_len;
            end else if (r_hs) begin
                beat_cnt <= beat_cnt + 8'd1;
            end
            if (r_hs && beat_err)
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ace_rd_arbiter.sv
// Directed bench for ace_rd_arbiter: single read, round-robin ties, backpressure,
// protocol errors and reset mid-burst, all against hand-computed expectations.
module tb_ace_rd_arbiter;

    localparam logic [31:0] A0 = 32'h0000_1000;
    localparam logic [31:0] A1 = 32'h0000_2000;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  s_arvalid;
    logic [1:0]  s_arready;
    logic [63:0] s_araddr;
    logic [15:0] s_arlen;
    logic [7:0]  s_arsnoop;
    logic [1:0]  s_rvalid;
    logic [1:0]  s_rready;
    logic [63:0] s_rdata;
    logic [3:0]  s_rresp;
    logic        s_rlast;
    logic        m_arvalid;
    logic        m_arready;
    logic [3:0]  m_arid;
    logic [31:0] m_araddr;
    logic [7:0]  m_arlen;
    logic [3:0]  m_arsnoop;
    logic        m_rvalid;
    logic        m_rready;
    logic [3:0]  m_rid;
    logic [63:0] m_rdata;
    logic [3:0]  m_rresp;
    logic        m_rlast;
    logic        m_rack;
    logic        err;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    ace_rd_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_arlen(s_arlen), .s_arsnoop(s_arsnoop),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
        .s_rresp(s_rresp), .s_rlast(s_rlast),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid),
        .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsnoop(m_arsnoop),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rack(m_rack), .err(err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        s_arvalid = '0;
        s_araddr  = {A1, A0};
        s_arlen   = '0;
        s_arsnoop = {4'h2, 4'h1};
        s_rready  = '0;
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        m_rid     = '0;
        m_rdata   = '0;
        m_rresp   = '0;
        m_rlast   = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_arvalid"}, m_arvalid, 0);
        check({tag, "_arready"}, s_arready, 0);
        check({tag, "_araddr"},  m_araddr,  0);
        check({tag, "_rvalid"},  s_rvalid,  0);
        check({tag, "_rready"},  m_rready,  0);
        check({tag, "_rdata"},   s_rdata,   0);
        check({tag, "_rack"},    m_rack,    0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Called at a negedge in IDLE; returns at the negedge after the AR handshake (DATA).
    task automatic ar_phase(input logic [1:0] req, input logic g, input int stall, input logic hold);
        logic [31:0] ea;
        logic [7:0]  el;
        logic [3:0]  es;
        logic [1:0]  ev;
        int          pulses;
        ea = g ? A1 : A0;
        el = g ? s_arlen[15:8] : s_arlen[7:0];
        es = g ? 4'h2 : 4'h1;
        ev = '0;
        ev[g] = 1'b1;
        pulses = 0;
        s_arvalid = req;
        m_arready = 1'b0;
        #1 check("idle_no_arvalid", m_arvalid, 0);
        tick();
        for (int k = 0; k < stall; k++) begin
            check("stall_arvalid", m_arvalid, 1);
            check("stall_araddr", m_araddr, ea);
            check("stall_arlen", m_arlen, el);
            if (s_arready[g]) pulses++;
            check("stall_arready", s_arready, 0);
            tick();
        end
        m_arready = 1'b1;
        #1;
        check("ar_valid", m_arvalid, 1);
        check("ar_id", m_arid, 4'(g));
        check("ar_addr", m_araddr, ea);
        check("ar_len", m_arlen, el);
        check("ar_snoop", m_arsnoop, es);
        check("ar_ready_route", s_arready, ev);
        if (s_arready[g]) pulses++;
        tick();
        m_arready = 1'b0;
        if (!hold) s_arvalid = '0;
        #1;
        if (s_arready[g]) pulses++;
        check("ar_pulse_once", pulses, 1);
        check("data_no_arvalid", m_arvalid, 0);
        check("data_ar_payload0", m_araddr, 0);
    endtask

    // Drives nbeats R beats to requester g; RLAST rides on beat index last_at.
    task automatic r_phase(input logic g, input int nbeats, input int last_at,
                           input logic [3:0] rid, input logic toggle);
        int         idx;
        int         cyc;
        logic       rdy;
        logic [1:0] ev;
        logic [63:0] d;
        idx = 0;
        cyc = 0;
        ev = '0;
        ev[g] = 1'b1;
        while (idx < nbeats && cyc < 64) begin
            rdy = toggle ? (cyc % 2 == 1) : 1'b1;
            d = 64'hDA7A_0000_0000_0000 + 64'(idx);
            m_rvalid = 1'b1;
            m_rid    = rid;
            m_rdata  = d;
            m_rresp  = 4'(idx);
            m_rlast  = (idx == last_at);
            s_rready = '0;
            s_rready[g] = rdy;
            #1;
            check("r_valid_route", s_rvalid, ev);
            check("r_ready", m_rready, rdy);
            check("r_data", s_rdata, d);
            check("r_resp", s_rresp, 4'(idx));
            check("r_last", s_rlast, (idx == last_at));
            check("r_no_rack", m_rack, 0);
            tick();
            if (rdy) idx++;
            cyc++;
        end
        check("r_beats_done", idx, nbeats);
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        s_rready = '0;
    endtask

    task automatic ack_phase();
        #1 check("rack_high", m_rack, 1);
        tick();
        check("rack_one_cycle", m_rack, 0);
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        tick();
        check_quiet("reset");
        check("reset_err", err, 0);
        tick();
        rst = 1'b0;

        // R traffic while idle is ignored and is not an error.
        m_rvalid = 1'b1;
        m_rid    = 4'h7;
        m_rlast  = 1'b1;
        #1 check("idle_rready", m_rready, 0);
        check("idle_rvalid", s_rvalid, 0);
        tick();
        check("idle_no_err", err, 0);
        clear_inputs();

        // Single 4-beat read from requester 0.
        s_arlen = {8'd0, 8'd3};
        ar_phase(2'b01, 1'b0, 0, 1'b0);
        r_phase(1'b0, 4, 3, 4'h0, 1'b0);
        ack_phase();
        check("single_err", err, 0);

        // Persistent tie: grants alternate starting with requester 0.
        do_reset();
        s_arlen = {8'd0, 8'd0};
        for (int t = 0; t < 4; t++) begin
            ar_phase(2'b11, 1'(t % 2), 0, 1'b1);
            r_phase(1'(t % 2), 1, 0, 4'(t % 2), 1'b0);
            ack_phase();
        end
        check("tie_err", err, 0);

        // Backpressure on AR and R for requester 1.
        do_reset();
        s_arlen = {8'd2, 8'd0};
        ar_phase(2'b10, 1'b1, 5, 1'b0);
        r_phase(1'b1, 3, 2, 4'h1, 1'b1);
        ack_phase();
        check("bp_err", err, 0);

        // Foreign RID sets err, which then stays set across a clean transaction.
        do_reset();
        s_arlen = {8'd0, 8'd0};
        ar_phase(2'b01, 1'b0, 0, 1'b0);
        r_phase(1'b0, 1, 0, 4'h1, 1'b0);
        check("rid_err_set", err, 1);
        ack_phase();
        ar_phase(2'b01, 1'b0, 0, 1'b0);
        r_phase(1'b0, 1, 0, 4'h0, 1'b0);
        ack_phase();
        check("rid_err_sticky", err, 1);

        // Early RLAST: arlen=1 but RLAST on beat 0.
        do_reset();
        check("len_err_cleared", err, 0);
        s_arlen = {8'd0, 8'd1};
        ar_phase(2'b01, 1'b0, 0, 1'b0);
        r_phase(1'b0, 1, 0, 4'h0, 1'b0);
        check("len_err_set", err, 1);
        ack_phase();

        // Reset during beat 2 of a 4-beat burst.
        do_reset();
        s_arlen = {8'd0, 8'd3};
        ar_phase(2'b01, 1'b0, 0, 1'b0);
        r_phase(1'b0, 2, 3, 4'h0, 1'b0);
        m_rvalid = 1'b1;
        m_rdata  = 64'hDA7A_0000_0000_0002;
        s_rready = 2'b01;
        #1 check("mid_rvalid", s_rvalid, 2'b01);
        rst = 1'b1;
        #1 check_quiet("mid_reset");
        check("mid_reset_err", err, 0);
        tick();
        clear_inputs();
        tick();
        check("mid_no_rack", m_rack, 0);
        rst = 1'b0;
        tick();
        check("post_rst_no_rack", m_rack, 0);
        s_arlen = {8'd0, 8'd3};
        ar_phase(2'b11, 1'b0, 0, 1'b0);
        r_phase(1'b0, 4, 3, 4'h0, 1'b0);
        ack_phase();
        check("post_rst_err", err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/ace_rd_arbiter.md
ACE_RD_ARBITER -- requirements
Module: ace_rd_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default ACE_AXADDR_WIDTH, AR address width.
REQ-002 SHALL have parameter DATA_WIDTH, default ACE_XDATA_WIDTH, R data width.
REQ-003 SHALL have parameter ID_WIDTH, default ACE_XID_WIDTH, AR/R ID width (>=1).
REQ-004 Ports (one clock; reset is asynchronous and active-high):
 clk  in  1  clock, all state on rising edge
 rst  in  1  asynchronous active-high reset
 s_arvalid[i]  in  1  AR request from requester i (i=0 IFU, i=1 LSU)
 s_arready[i]  out  1  AR accept to requester i
 s_araddr[i]  in  ADDR_WIDTH  read address
 s_arlen[i]  in  8  burst length minus 1
 s_arsnoop[i]  in  4  ARSNOOP
 s_rvalid[i]  out  1  R beat to requester i
 s_rready[i]  in  1  R accept from requester i
 s_rdata  out  DATA_WIDTH  shared R data (valid only with s_rvalid[i])
 s_rresp  out  4  shared RRESP
 s_rlast  out  1  shared RLAST
 m_arvalid/m_arready  out/in  1  downstream AR handshake
 m_arid  out  ID_WIDTH  downstream ARID
 m_araddr, m_arlen, m_arsnoop  out  ADDR_WIDTH/8/4  downstream AR payload
 m_rvalid/m_rready  in/out  1  downstream R handshake
 m_rid  in  ID_WIDTH;  m_rdata in DATA_WIDTH;  m_rresp in 4;  m_rlast in 1
 m_rack  out  1  ACE RACK
 err  out  1  sticky protocol error flag

Function
REQ-005 SHALL implement FSM states IDLE, ADDR, DATA, ACK; exactly one transaction outstanding at a time.
REQ-006 IDLE: if any s_arvalid, SHALL grant one requester and move to ADDR next cycle; otherwise stay.
REQ-007 Arbitration SHALL be round-robin: both valid -> grant requester not granted last; one valid -> grant it; last-grant register updates on grant.
REQ-008 ADDR: m_arvalid=1; m_araddr/m_arlen/m_arsnoop SHALL pass through from granted requester; m_arid = grant index zero-extended; s_arready[g]=m_arready; on m_arvalid&&m_arready SHALL go to DATA and load beat counter with 0 and expected length with s_arlen[g].
REQ-009 Outside ADDR, m_arvalid and all s_arready SHALL be 0; m_ar* payload SHALL be 0.
REQ-010 DATA: s_rvalid[g]=m_rvalid, m_rready=s_rready[g], s_rdata/s_rresp/s_rlast=m_r* (combinational, zero latency); other requester s_rvalid=0.
REQ-011 Each R handshake in DATA SHALL increment beat counter (8-bit, wraps, no saturation).
REQ-012 On R handshake with m_rlast=1 SHALL go to ACK; m_rlast SHALL be the only DATA exit.
REQ-013 err SHALL set on an R handshake where m_rid != granted ID, or m_rlast=1 with counter != expected length, or m_rlast=0 with counter == expected length; data still forwarded.
REQ-014 ACK: m_rack=1 for exactly one cycle, then IDLE; m_rack=0 in all other states.
REQ-015 m_rvalid in IDLE/ADDR/ACK SHALL be ignored (m_rready=0), not error.
REQ-016 Minimum request-to-request spacing: AR grant in IDLE at cycle N -> m_arvalid at N+1; back-to-back transactions SHALL re-enter IDLE after ACK (no IDLE bypass).

Reset
REQ-017 rst asserted SHALL immediately force IDLE, last-grant=1 (requester 0 wins first tie), beat counter=0, err=0, all outputs 0.
REQ-018 Reset mid-transaction SHALL abandon it with no m_rack; err SHALL clear only on reset.

Verification
REQ-019 Single read: s_arvalid[0], araddr=0x1000, arlen=3 -> m_arvalid next cycle, m_arid=0; 4 beats to s_rvalid[0]; m_rack one cycle after rlast beat; err=0.
REQ-020 Tie: both s_arvalid held after reset -> grants 0,1,0,1 across four transactions; m_arid follows grant.
REQ-021 Backpressure: m_arready low 5 cycles, s_rready[1] toggling -> payload stable, no lost/duplicated beats, s_arready[1] pulses once.
REQ-022 Errors: m_rid=1 while granted 0 -> err=1 and stays; separately arlen=1 with rlast on beat 0 -> err=1.
REQ-023 rst asserted during DATA beat 2 -> outputs 0 same cycle, no m_rack; next request from requester 0 wins tie.
